// File: rtl/keccak_pkg.sv
// Shared Keccak constants: lane geometry, rho rotation table and the
// inverse-rho sequencer state encoding.
package keccak_pkg;

  localparam int unsigned KECCAK_X     = 5;
  localparam int unsigned KECCAK_Y     = 5;
  localparam int unsigned KECCAK_Z     = 64;
  localparam int unsigned KECCAK_LANES = KECCAK_X * KECCAK_Y;
  localparam int unsigned LANE_IDX_W   = 5;
  localparam int unsigned ROT_W        = 6;

  // Rho offsets mod 64, indexed by lane L = 5*x + y (entry 0 is the LSB slot).
  localparam logic [KECCAK_LANES-1:0][ROT_W-1:0] RHO_ROT = {
    6'd14, 6'd8,  6'd39, 6'd20, 6'd27,   // x=4, y=4..0
    6'd56, 6'd21, 6'd25, 6'd55, 6'd28,   // x=3
    6'd61, 6'd15, 6'd43, 6'd6,  6'd62,   // x=2
    6'd2,  6'd45, 6'd10, 6'd44, 6'd1,    // x=1
    6'd18, 6'd41, 6'd3,  6'd36, 6'd0     // x=0
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } rho_state_e;

endpackage

// File: rtl/lane_rotr.sv
// Combinational 64-bit rotate-right by a 6-bit amount.
module lane_rotr
  import keccak_pkg::*;
(
  input  logic [KECCAK_Z-1:0] data,
  input  logic [ROT_W-1:0]    amount,
  output logic [KECCAK_Z-1:0] rot_c
);

  // A left shift by the full width yields zero, which covers amount == 0.
  assign rot_c = (data >> amount) | (data << (7'(KECCAK_Z) - {1'b0, amount}));

endmodule

// File: rtl/perm_rho_inv_seq.sv
// Sequential inverse rho: rotates one lane per cycle through a single shared
// rotator, writing each result back into the captured state in place.
module perm_rho_inv_seq
  import keccak_pkg::*;
#(
  parameter int unsigned X_AXIS = KECCAK_X,
  parameter int unsigned Y_AXIS = KECCAK_Y,
  parameter int unsigned Z_AXIS = KECCAK_Z
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0] in_data,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0] out_data,
  output logic                                    busy
);

  localparam int unsigned STATE_W     = X_AXIS * Y_AXIS * Z_AXIS;
  localparam int unsigned LAST_LANE   = X_AXIS * Y_AXIS - 1;
  localparam int unsigned LANE_BASE_W = $clog2(STATE_W);

  rho_state_e              state_q, state_d;
  logic [LANE_IDX_W-1:0]   lane_q, lane_d;
  logic [STATE_W-1:0]      st_q, st_d;
  logic                    in_ready_q, out_valid_q, busy_q;
  logic [LANE_BASE_W-1:0]  lane_base;
  logic [Z_AXIS-1:0]       lane_data;
  logic [Z_AXIS-1:0]       lane_rot_c;

  // Lane L occupies bits [L*64 +: 64] of the flattened [x][y][z] state.
  assign lane_base = LANE_BASE_W'(lane_q) * LANE_BASE_W'(Z_AXIS);
  assign lane_data = st_q[lane_base +: Z_AXIS];

  lane_rotr u_lane_rotr (
    .data   (lane_data),
    .amount (RHO_ROT[lane_q]),
    .rot_c  (lane_rot_c)
  );

  // Next-state, lane counter and state write-back.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    st_d    = st_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          st_d    = in_data;
          lane_d  = '0;
          state_d = ROT;
        end
      end
      ROT: begin
        st_d[lane_base +: Z_AXIS] = lane_rot_c;
        if (lane_q == LANE_IDX_W'(LAST_LANE)) begin
          state_d = DONE;
        end else begin
          lane_d = lane_q + LANE_IDX_W'(1);
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are registered copies of the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lane_q      <= '0;
      st_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      st_q        <= st_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = st_q;

endmodule

// File: tb/tb_perm_rho_inv_seq.sv
// Directed and random checks for the sequential inverse-rho block.
module tb_perm_rho_inv_seq;

  typedef logic [4:0][4:0][63:0] st_t;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic in_ready;
  st_t  in_data;
  logic out_valid;
  logic out_ready;
  st_t  out_data;
  logic busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Rho offsets, row x = 0..4, column y = 0..4.
  int unsigned rho_tab [5][5] = '{
    '{ 0, 36,  3, 41, 18},
    '{ 1, 44, 10, 45,  2},
    '{62,  6, 43, 15, 61},
    '{28, 55, 25, 21, 56},
    '{27, 20, 39,  8, 14}
  };

  perm_rho_inv_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input st_t obs, input st_t exp);
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        check(tag, obs[x][y], exp[x][y]);
  endtask

  function automatic logic [63:0] rotl(input logic [63:0] v, input int unsigned r);
    if (r == 0) return v;
    return (v << r) | (v >> (64 - r));
  endfunction

  function automatic st_t rho_fwd(input st_t s);
    st_t o;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        o[x][y] = rotl(s[x][y], rho_tab[x][y]);
    return o;
  endfunction

  function automatic st_t rand_state();
    st_t s;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        s[x][y] = {$urandom, $urandom};
    return s;
  endfunction

  // One full transaction; lat counts edges from the accept edge to out_valid.
  task automatic transact(input st_t din, output st_t dout, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    in_valid = 1'b1;
    in_data  = din;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    dout = out_data;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  st_t  din, dout, expv, snap, s_rand;
  int   lat, w, cyc, na, no;
  logic saw_ov, acc;
  st_t  vecs [4];
  st_t  exps [4];
  int   acc_cyc [4];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_out_data_zero", 64'(|out_data), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);

    // Single bit: [0][1] bit 36 lands on bit 0.
    din = '0; din[0][1][36] = 1'b1;
    expv = '0; expv[0][1][0] = 1'b1;
    transact(din, dout, lat);
    check("single_latency", 64'(lat), 64'd26);
    check_state("single_bit", dout, expv);
    check("single_in_ready_after", 64'(in_ready), 64'd1);
    check("single_out_valid_after", 64'(out_valid), 64'd0);

    // Wrap: [4][4] bit 0 lands on bit 50.
    din = '0; din[4][4][0] = 1'b1;
    expv = '0; expv[4][4][50] = 1'b1;
    transact(din, dout, lat);
    check("wrap_latency", 64'(lat), 64'd26);
    check_state("wrap_bit", dout, expv);

    // Lane [2][0] bit 0 rotated right by 62 lands on bit 2.
    din = '0; din[2][0][0] = 1'b1;
    expv = '0; expv[2][0][2] = 1'b1;
    transact(din, dout, lat);
    check_state("lane20_bit", dout, expv);

    // Backpressure in DONE with ignored input pulses.
    s_rand = rand_state();
    in_valid = 1'b1; in_data = rho_fwd(s_rand);
    @(posedge clk); #1;
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 100) begin
      @(posedge clk); #1; w++;
    end
    check("bp_reach_done", 64'(out_valid), 64'd1);
    snap = out_data;
    check_state("bp_data", snap, s_rand);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = rand_state();
      @(posedge clk); #1;
      check("bp_stable", 64'(out_data != snap), 64'd0);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_in_ready_after", 64'(in_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("bp_no_stray_accept", 64'(busy), 64'd0);

    // Reset while lane 12 is being rotated.
    in_valid = 1'b1; in_data = rand_state();
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("mid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_data_zero", 64'(|out_data), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw_ov = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      saw_ov = saw_ov | out_valid;
    end
    check("mid_rst_no_out_valid", 64'(saw_ov), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_busy_after", 64'(busy), 64'd0);

    // Back-to-back stream with both handshakes held high.
    for (int i = 0; i < 4; i++) begin
      exps[i] = rand_state();
      vecs[i] = rho_fwd(exps[i]);
      acc_cyc[i] = 0;
    end
    na = 0; no = 0; cyc = 0;
    in_data = vecs[0]; in_valid = 1'b1; out_ready = 1'b1;
    while ((na < 4 || no < 4) && cyc < 400) begin
      acc = in_valid && in_ready;
      if (out_valid && no < 4) begin
        check_state("b2b_data", out_data, exps[no]);
        no++;
      end
      if (acc) begin
        acc_cyc[na] = cyc;
        na++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        if (na < 4) in_data = vecs[na];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b_accepts", 64'(na), 64'd4);
    check("b2b_results", 64'(no), 64'd4);
    for (int i = 1; i < 4; i++)
      check("b2b_interval", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd27);

    // Random round trips through the forward rho model.
    for (int i = 0; i < 1000; i++) begin
      s_rand = rand_state();
      transact(rho_fwd(s_rand), dout, lat);
      check("rt_latency", 64'(lat), 64'd26);
      check_state("round_trip", dout, s_rand);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
